// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: opcode and FSM state enums shared by alu_mc and alu_mc_divcore.
package alu_mc_pkg;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_NEG = 4'd2,
      OP_MUL = 4'd3,
      OP_DIV = 4'd4,
      OP_AND = 4'd5,
      OP_OR  = 4'd6,
      OP_ROR = 4'd7,
      OP_ROL = 4'd8,
      OP_SLL = 4'd9,
      OP_SRA = 4'd10,
      OP_SRL = 4'd11,
      OP_NOT = 4'd12,
      OP_INC = 4'd13
   } alu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } alu_state_t;

   localparam int FLAGS_W = 4;

endpackage

// File: rtl/alu_mc_divcore.sv
// alu_mc_divcore: signed restoring divider on magnitudes. The start edge performs the
// first iteration; done is high for the cycle after the last iteration (sign fixup).
module alu_mc_divcore
   import alu_mc_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic             busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dmag_q, dmag_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;

   logic [WIDTH-1:0] dvd_mag_s, dvs_mag_s;
   logic [WIDTH-1:0] src_rem_s, src_quo_s, src_dvs_s;
   logic [WIDTH:0]   shift_s, diff_s;
   logic [WIDTH-1:0] step_rem_s, step_quo_s;

   // One restoring step; on the start edge it works straight from the operand magnitudes.
   always_comb begin
      dvd_mag_s = dividend[WIDTH-1] ? -dividend : dividend;
      dvs_mag_s = divisor[WIDTH-1] ? -divisor : divisor;
      if (start) begin
         src_rem_s = {WIDTH{1'b0}};
         src_quo_s = dvd_mag_s;
         src_dvs_s = dvs_mag_s;
      end else begin
         src_rem_s = rem_q;
         src_quo_s = quo_q;
         src_dvs_s = dmag_q;
      end
      shift_s    = {src_rem_s, src_quo_s[WIDTH-1]};
      diff_s     = shift_s - {1'b0, src_dvs_s};
      step_rem_s = diff_s[WIDTH] ? shift_s[WIDTH-1:0] : diff_s[WIDTH-1:0];
      step_quo_s = {src_quo_s[WIDTH-2:0], ~diff_s[WIDTH]};
   end

   // Iteration sequencing: start loads, then step until WIDTH iterations are done.
   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      rem_d  = rem_q;
      quo_d  = quo_q;
      dmag_d = dmag_q;
      qneg_d = qneg_q;
      rneg_d = rneg_q;
      if (start) begin
         busy_d = 1'b1;
         cnt_d  = {{(CNT_W-1){1'b0}}, 1'b1};
         rem_d  = step_rem_s;
         quo_d  = step_quo_s;
         dmag_d = dvs_mag_s;
         qneg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
         rneg_d = dividend[WIDTH-1];
      end else if (busy_q && (cnt_q != CNT_W'(WIDTH))) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         rem_d = step_rem_s;
         quo_d = step_quo_s;
      end else begin
         busy_d = 1'b0;
      end
   end

   // Divider state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= 1'b0;
         cnt_q  <= {CNT_W{1'b0}};
         rem_q  <= {WIDTH{1'b0}};
         quo_q  <= {WIDTH{1'b0}};
         dmag_q <= {WIDTH{1'b0}};
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dmag_q <= dmag_d;
         qneg_q <= qneg_d;
         rneg_q <= rneg_d;
      end
   end

   assign done      = busy_q && (cnt_q == CNT_W'(WIDTH));
   assign quotient  = qneg_q ? -quo_q : quo_q;
   assign remainder = rneg_q ? -rem_q : rem_q;

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with single-cycle ops, Booth multiplier and iterative divider.
// Define ALU_MC_FLAGS_EN to add the {N,Z,C,V} flags output.
module alu_mc
   import alu_mc_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         op,
   input  logic [WIDTH-1:0]   x,
   input  logic [WIDTH-1:0]   y,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] z,
`ifdef ALU_MC_FLAGS_EN
   output logic [FLAGS_W-1:0] flags,
`endif
   output logic               div_by_zero
);

   localparam int SHAMT_W = $clog2(WIDTH);
   localparam int MCNT_W  = $clog2(WIDTH);
   localparam int PW      = 2 * WIDTH + 2;

   alu_state_t         state_q, state_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic [2*WIDTH-1:0] z_q, z_d;
   logic               dbz_q, dbz_d;
   logic [WIDTH:0]     m_q, m_d;
   logic [PW-1:0]      p_q, p_d;
   logic [MCNT_W-1:0]  cnt_q, cnt_d;

   logic [SHAMT_W-1:0] sh_s;
   logic [SHAMT_W:0]   sh_inv_s;
   logic [WIDTH-1:0]   res_s;
   logic [PW-1:0]      booth_s;
   logic               div_start_s, div_done_s;
   logic [WIDTH-1:0]   div_quo_s, div_rem_s;

   // Booth product register layout is {A[WIDTH:0], Q[WIDTH-1:0], q_-1}; A has a guard bit
   // so subtracting the most negative multiplicand cannot overflow.
   function automatic logic [PW-1:0] booth_step(input logic [PW-1:0] p, input logic [WIDTH:0] m);
      logic [WIDTH:0] a;
      a = p[PW-1:WIDTH+1];
      case (p[1:0])
         2'b01:   a = a + m;
         2'b10:   a = a - m;
         default: a = a;
      endcase
      booth_step = $signed({a, p[WIDTH:0]}) >>> 1;
   endfunction

   assign sh_s    = y[SHAMT_W-1:0];
   assign booth_s = booth_step(p_q, m_q);

   // Single-cycle datapath on the live operands (sampled at the accept edge).
   always_comb begin
      sh_inv_s = (SHAMT_W+1)'(WIDTH) - {1'b0, sh_s};
      case (op)
         OP_ADD:  res_s = x + y;
         OP_SUB:  res_s = x - y;
         OP_NEG:  res_s = {WIDTH{1'b0}} - x;
         OP_INC:  res_s = x + {{(WIDTH-1){1'b0}}, 1'b1};
         OP_AND:  res_s = x & y;
         OP_OR:   res_s = x | y;
         OP_NOT:  res_s = ~x;
         OP_SLL:  res_s = x << sh_s;
         OP_SRL:  res_s = x >> sh_s;
         OP_SRA:  res_s = $signed(x) >>> sh_s;
         OP_ROL:  res_s = (x << sh_s) | (x >> sh_inv_s);
         OP_ROR:  res_s = (x >> sh_s) | (x << sh_inv_s);
         default: res_s = {WIDTH{1'b0}};
      endcase
   end

`ifdef ALU_MC_FLAGS_EN
   logic [FLAGS_W-1:0] flags_q, flags_d;
   logic               alu_c_s, alu_v_s;

   // Carry is not-borrow for SUB/NEG; overflow from operand and result signs.
   always_comb begin
      alu_c_s = 1'b0;
      alu_v_s = 1'b0;
      case (op)
         OP_ADD: begin
            alu_c_s = (res_s < x);
            alu_v_s = (x[WIDTH-1] == y[WIDTH-1]) && (res_s[WIDTH-1] != x[WIDTH-1]);
         end
         OP_SUB: begin
            alu_c_s = (x >= y);
            alu_v_s = (x[WIDTH-1] != y[WIDTH-1]) && (res_s[WIDTH-1] != x[WIDTH-1]);
         end
         OP_NEG: begin
            alu_c_s = (x == {WIDTH{1'b0}});
            alu_v_s = (x == {1'b1, {(WIDTH-1){1'b0}}});
         end
         OP_INC: begin
            alu_c_s = (x == {WIDTH{1'b1}});
            alu_v_s = (x == {1'b0, {(WIDTH-1){1'b1}}});
         end
         default: begin
            alu_c_s = 1'b0;
            alu_v_s = 1'b0;
         end
      endcase
   end
`endif

   // Control FSM next-state and registered-output computation.
   always_comb begin
      state_d     = state_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      z_d         = z_q;
      dbz_d       = dbz_q;
      m_d         = m_q;
      p_d         = p_q;
      cnt_d       = cnt_q;
      div_start_s = 1'b0;
`ifdef ALU_MC_FLAGS_EN
      flags_d     = flags_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               in_ready_d = 1'b0;
               if (op == OP_MUL) begin
                  m_d     = {x[WIDTH-1], x};
                  p_d     = booth_step({{(WIDTH+1){1'b0}}, y, 1'b0}, {x[WIDTH-1], x});
                  cnt_d   = {{(MCNT_W-1){1'b0}}, 1'b1};
                  state_d = ST_MUL;
               end else if ((op == OP_DIV) && (y != {WIDTH{1'b0}})) begin
                  div_start_s = 1'b1;
                  state_d     = ST_DIV;
               end else if (op == OP_DIV) begin
                  z_d         = {x, {WIDTH{1'b1}}};
                  dbz_d       = 1'b1;
                  out_valid_d = 1'b1;
                  state_d     = ST_DONE;
`ifdef ALU_MC_FLAGS_EN
                  flags_d     = 4'b1000;
`endif
               end else begin
                  z_d         = {{WIDTH{1'b0}}, res_s};
                  dbz_d       = 1'b0;
                  out_valid_d = 1'b1;
                  state_d     = ST_DONE;
`ifdef ALU_MC_FLAGS_EN
                  flags_d     = {res_s[WIDTH-1], (res_s == {WIDTH{1'b0}}), alu_c_s, alu_v_s};
`endif
               end
            end else begin
               in_ready_d = 1'b1;
            end
         end
         ST_MUL: begin
            p_d   = booth_s;
            cnt_d = cnt_q + {{(MCNT_W-1){1'b0}}, 1'b1};
            if (cnt_q == MCNT_W'(WIDTH - 1)) begin
               z_d         = booth_s[2*WIDTH:1];
               dbz_d       = 1'b0;
               out_valid_d = 1'b1;
               state_d     = ST_DONE;
`ifdef ALU_MC_FLAGS_EN
               flags_d     = {booth_s[2*WIDTH], (booth_s[2*WIDTH:1] == {(2*WIDTH){1'b0}}), 2'b00};
`endif
            end else begin
               state_d = ST_MUL;
            end
         end
         ST_DIV: begin
            if (div_done_s) begin
               z_d         = {div_rem_s, div_quo_s};
               dbz_d       = 1'b0;
               out_valid_d = 1'b1;
               state_d     = ST_DONE;
`ifdef ALU_MC_FLAGS_EN
               flags_d     = {div_quo_s[WIDTH-1], (div_quo_s == {WIDTH{1'b0}}), 2'b00};
`endif
            end else begin
               state_d = ST_DIV;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               out_valid_d = 1'b1;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // FSM and output registers; reset aborts any multiply or divide in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         z_q         <= {(2*WIDTH){1'b0}};
         dbz_q       <= 1'b0;
         m_q         <= {(WIDTH+1){1'b0}};
         p_q         <= {PW{1'b0}};
         cnt_q       <= {MCNT_W{1'b0}};
`ifdef ALU_MC_FLAGS_EN
         flags_q     <= {FLAGS_W{1'b0}};
`endif
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         z_q         <= z_d;
         dbz_q       <= dbz_d;
         m_q         <= m_d;
         p_q         <= p_d;
         cnt_q       <= cnt_d;
`ifdef ALU_MC_FLAGS_EN
         flags_q     <= flags_d;
`endif
      end
   end

   alu_mc_divcore #(.WIDTH(WIDTH)) u_divcore (
      .clk       (clk),
      .reset     (reset),
      .start     (div_start_s),
      .dividend  (x),
      .divisor   (y),
      .done      (div_done_s),
      .quotient  (div_quo_s),
      .remainder (div_rem_s)
   );

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign z           = z_q;
   assign div_by_zero = dbz_q;
`ifdef ALU_MC_FLAGS_EN
   assign flags       = flags_q;
`endif

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc (WIDTH=32); flags checked when ALU_MC_FLAGS_EN is defined.
module tb_alu_mc;
   import alu_mc_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  op;
   logic [31:0] x;
   logic [31:0] y;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] z;
   logic        div_by_zero;
`ifdef ALU_MC_FLAGS_EN
   logic [3:0]  flags;
`endif

   int errors = 0;
   int checks = 0;
   int lat;

   always #5 clk = ~clk;

   alu_mc #(.WIDTH(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .op          (op),
      .x           (x),
      .y           (y),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .z           (z),
`ifdef ALU_MC_FLAGS_EN
      .flags       (flags),
`endif
      .div_by_zero (div_by_zero)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one request, scramble inputs after the accept edge, count edges until out_valid.
   task automatic run(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      op       = o;
      x        = a;
      y        = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op       = 4'd0;
      x        = 32'hDEAD_BEEF;
      y        = 32'h0BAD_F00D;
      lat      = 1;
      while (out_valid !== 1'b1 && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic drain();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      op        = 4'd0;
      x         = 32'd0;
      y         = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_z", z, 64'd0);
      chk("rst_dbz", 64'(div_by_zero), 64'd0);

      run(OP_ADD, 32'd10, 32'd5);
      chk("add_lat", 64'(lat), 64'd1);
      chk("add_z", z, 64'h0000_0000_0000_000F);
      chk("add_dbz", 64'(div_by_zero), 64'd0);
      drain();
      chk("add_back_idle", 64'(in_ready), 64'd1);

      run(OP_SUB, 32'd3, 32'd5);
      chk("sub_z", z, 64'h0000_0000_FFFF_FFFE);
      drain();
      run(OP_NEG, 32'd1, 32'd0);
      chk("neg_z", z, 64'h0000_0000_FFFF_FFFF);
      drain();
      run(OP_INC, 32'hFFFF_FFFF, 32'd0);
      chk("inc_wrap_z", z, 64'h0000_0000_0000_0000);
      drain();
      run(OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
      chk("and_z", z, 64'h0000_0000_00F0_00F0);
      drain();
      run(OP_OR, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
      chk("or_z", z, 64'h0000_0000_FFF0_FFF0);
      drain();
      run(OP_NOT, 32'h0000_FFFF, 32'd0);
      chk("not_z", z, 64'h0000_0000_FFFF_0000);
      drain();
      run(OP_SLL, 32'd1, 32'h0000_0104);
      chk("sll_upper_y_ignored", z, 64'h0000_0000_0000_0010);
      drain();
      run(OP_SRL, 32'h8000_0000, 32'd31);
      chk("srl_z", z, 64'h0000_0000_0000_0001);
      drain();
      run(OP_SRA, 32'h8000_0000, 32'd4);
      chk("sra_z", z, 64'h0000_0000_F800_0000);
      drain();
      run(OP_ROR, 32'd1, 32'd1);
      chk("ror_z", z, 64'h0000_0000_8000_0000);
      drain();

      run(OP_MUL, 32'hFFFF_FFFD, 32'd7);
      chk("mul_lat", 64'(lat), 64'd32);
      chk("mul_z", z, 64'hFFFF_FFFF_FFFF_FFEB);
      chk("mul_dbz", 64'(div_by_zero), 64'd0);
      drain();
      run(OP_MUL, 32'h8000_0000, 32'h8000_0000);
      chk("mul_min_min_z", z, 64'h4000_0000_0000_0000);
      drain();

      run(OP_DIV, 32'hFFFF_FFF9, 32'd2);
      chk("div_lat", 64'(lat), 64'd33);
      chk("div_z", z, 64'hFFFF_FFFF_FFFF_FFFD);
      drain();
      run(OP_DIV, 32'd20, 32'd0);
      chk("div0_lat", 64'(lat), 64'd1);
      chk("div0_z", z, 64'h0000_0014_FFFF_FFFF);
      chk("div0_dbz", 64'(div_by_zero), 64'd1);
      drain();
      run(4'd14, 32'd5, 32'd5);
      chk("rsvd_lat", 64'(lat), 64'd1);
      chk("rsvd_z", z, 64'd0);
      chk("rsvd_dbz", 64'(div_by_zero), 64'd0);
      drain();
      run(OP_DIV, 32'd7, 32'hFFFF_FFFE);
      chk("div_negdvs_z", z, 64'h0000_0001_FFFF_FFFD);
      drain();

`ifdef ALU_MC_FLAGS_EN
      run(OP_ADD, 32'h7FFF_FFFF, 32'd1);
      chk("flags_add_ovf", 64'(flags), 64'h9);
      drain();
      run(OP_SUB, 32'd5, 32'd5);
      chk("flags_sub_zero", 64'(flags), 64'h6);
      drain();
`endif

      out_ready = 1'b0;
      run(OP_ROL, 32'h8000_0001, 32'd33);
      chk("rol_lat", 64'(lat), 64'd1);
      chk("rol_z", z, 64'h0000_0000_0000_0003);
      in_valid = 1'b1;
      op       = OP_ADD;
      x        = 32'd1;
      y        = 32'd1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("hold_z", z, 64'h0000_0000_0000_0003);
         chk("hold_valid", 64'(out_valid), 64'd1);
         chk("hold_in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("release_valid", 64'(out_valid), 64'd0);
      chk("release_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      chk("no_accept_in_done", 64'(out_valid), 64'd0);

      op       = OP_MUL;
      x        = 32'hFFFF_FFFD;
      y        = 32'd7;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      chk("mul_busy_in_ready", 64'(in_ready), 64'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("abort_valid", 64'(out_valid), 64'd0);
      chk("abort_in_ready", 64'(in_ready), 64'd1);
      chk("abort_z", z, 64'd0);
      run(OP_ADD, 32'd10, 32'd5);
      chk("post_abort_lat", 64'(lat), 64'd1);
      chk("post_abort_z", z, 64'h0000_0000_0000_000F);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
